pipelined_segmented_adder: RTL and testbench

Parametrised, pipelined successor to the single-cycle ripple carry adder. The DATA_WIDTH carry chain is cut into NUM_STAGES equal segments, with one register stage per segment. This gives one result per cycle at high clock rate. Adds add/subtract mode, status flags and a valid/ready handshake, so the block drops into streaming datapaths (ALU back end, accumulators, DSP chains).

---
 rtl/pipelined_segmented_adder.sv | 183 ++++++++++++++++++
 tb/tb_pipelined_segmented_adder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_segmented_adder.sv
// Pipelined add/subtract unit. The carry chain is cut into NUM_STAGES registered
// segments. A global valid/ready stall holds every stage together.
module pipelined_segmented_adder #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_STAGES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  carry_in,
  input  logic                  sub_in,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic [DATA_WIDTH-1:0] sum_out,
  output logic                  carry_out,
  output logic                  overflow_out,
  output logic                  zero_out
);

  localparam int SEG_W     = DATA_WIDTH / NUM_STAGES;
  localparam int SUM_BITS  = SEG_W * NUM_STAGES * (NUM_STAGES + 1) / 2;
  localparam int SKEW_W    = SEG_W * NUM_STAGES * (NUM_STAGES - 1) / 2;
  localparam int SKEW_BITS = (SKEW_W > 0) ? SKEW_W : 1;

  if ((NUM_STAGES < 1) || (NUM_STAGES > DATA_WIDTH) || ((DATA_WIDTH % NUM_STAGES) != 0)) begin : g_param_check
    $error("pipelined_segmented_adder: DATA_WIDTH must be a multiple of NUM_STAGES");
  end

  // Stage k keeps the finished low (k+1) segments; the flat vector packs them.
  function automatic int sum_off(input int k);
    return SEG_W * k * (k + 1) / 2;
  endfunction

  // Stage k keeps the not-yet-added upper operand segments (NUM_STAGES-1-k of them).
  function automatic int skew_off(input int k);
    return SEG_W * (k * (NUM_STAGES - 1) - k * (k - 1) / 2);
  endfunction

  logic                  adv;
  logic [DATA_WIDTH-1:0] b_eff;
  logic                  carry_eff;

  wire [NUM_STAGES-1:0] stg_valid;
  wire [NUM_STAGES-1:0] stg_carry;
  wire [NUM_STAGES-1:0] stg_a_msb;
  wire [NUM_STAGES-1:0] stg_b_msb;
  wire [SUM_BITS-1:0]   stg_sum;
  wire [SKEW_BITS-1:0]  stg_a_skew;
  wire [SKEW_BITS-1:0]  stg_b_skew;
  wire                  stg_zero;

  assign adv       = !valid_out || ready_out;
  assign ready_in  = adv;
  assign b_eff     = sub_in ? ~b_in : b_in;
  assign carry_eff = sub_in ? 1'b1 : carry_in;

  if (NUM_STAGES == 1) begin : g_no_skew
    assign stg_a_skew = '0;
    assign stg_b_skew = '0;
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int HI   = (k + 1) * SEG_W;
    localparam int SOFF = sum_off(k);

    logic             valid_i;
    logic             carry_i;
    logic             a_msb_i;
    logic             b_msb_i;
    logic [SEG_W-1:0] seg_a;
    logic [SEG_W-1:0] seg_b;
    logic [SEG_W:0]   seg_res;
    logic [HI-1:0]    sum_d;
    logic             load;

    logic             valid_r;
    logic             carry_r;
    logic             a_msb_r;
    logic             b_msb_r;
    logic [HI-1:0]    sum_r;

    if (k == 0) begin : g_head
      assign valid_i = valid_in;
      assign carry_i = carry_eff;
      assign a_msb_i = a_in[DATA_WIDTH-1];
      assign b_msb_i = b_eff[DATA_WIDTH-1];
      assign seg_a   = a_in[SEG_W-1:0];
      assign seg_b   = b_eff[SEG_W-1:0];
      assign sum_d   = seg_res[SEG_W-1:0];
    end else begin : g_body
      localparam int LO = k * SEG_W;
      assign valid_i = stg_valid[k-1];
      assign carry_i = stg_carry[k-1];
      assign a_msb_i = stg_a_msb[k-1];
      assign b_msb_i = stg_b_msb[k-1];
      assign seg_a   = stg_a_skew[skew_off(k-1) +: SEG_W];
      assign seg_b   = stg_b_skew[skew_off(k-1) +: SEG_W];
      assign sum_d   = {seg_res[SEG_W-1:0], stg_sum[sum_off(k-1) +: LO]};
    end

    assign seg_res = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG_W{1'b0}}, carry_i};
    // Data registers load only for real beats; bubbles move just the valid bit.
    assign load    = adv && valid_i;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_r <= 1'b0;
        carry_r <= 1'b0;
        a_msb_r <= 1'b0;
        b_msb_r <= 1'b0;
        sum_r   <= '0;
      end else begin
        if (adv) begin
          valid_r <= valid_i;
        end
        if (load) begin
          carry_r <= seg_res[SEG_W];
          a_msb_r <= a_msb_i;
          b_msb_r <= b_msb_i;
          sum_r   <= sum_d;
        end
      end
    end

    assign stg_valid[k]         = valid_r;
    assign stg_carry[k]         = carry_r;
    assign stg_a_msb[k]         = a_msb_r;
    assign stg_b_msb[k]         = b_msb_r;
    assign stg_sum[SOFF +: HI]  = sum_r;

    if (k < NUM_STAGES - 1) begin : g_skew
      localparam int REM = DATA_WIDTH - HI;
      logic [REM-1:0] a_rem_d;
      logic [REM-1:0] b_rem_d;
      logic [REM-1:0] a_rem_r;
      logic [REM-1:0] b_rem_r;

      if (k == 0) begin : g_src_in
        assign a_rem_d = a_in[DATA_WIDTH-1:SEG_W];
        assign b_rem_d = b_eff[DATA_WIDTH-1:SEG_W];
      end else begin : g_src_prev
        assign a_rem_d = stg_a_skew[skew_off(k-1) + SEG_W +: REM];
        assign b_rem_d = stg_b_skew[skew_off(k-1) + SEG_W +: REM];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_rem_r <= '0;
          b_rem_r <= '0;
        end else if (load) begin
          a_rem_r <= a_rem_d;
          b_rem_r <= b_rem_d;
        end
      end

      assign stg_a_skew[skew_off(k) +: REM] = a_rem_r;
      assign stg_b_skew[skew_off(k) +: REM] = b_rem_r;
    end

    if (k == NUM_STAGES - 1) begin : g_tail
      logic zero_r;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          zero_r <= 1'b0;
        end else if (load) begin
          zero_r <= (sum_d == '0);
        end
      end
      assign stg_zero = zero_r;
    end
  end

  assign valid_out    = stg_valid[NUM_STAGES-1];
  assign sum_out      = stg_sum[sum_off(NUM_STAGES-1) +: DATA_WIDTH];
  assign carry_out    = stg_carry[NUM_STAGES-1];
  assign zero_out     = stg_zero;
  assign overflow_out = (stg_a_msb[NUM_STAGES-1] == stg_b_msb[NUM_STAGES-1]) &&
                        (sum_out[DATA_WIDTH-1] != stg_a_msb[NUM_STAGES-1]);

endmodule

// File: tb/tb_pipelined_segmented_adder.sv
// Bench for pipelined_segmented_adder: three configurations share stimulus, each
// with its own scoreboard fed by an arithmetic reference model.
module tb_pipelined_segmented_adder;

  typedef struct {
    longint sum;
    logic   c;
    logic   ov;
    logic   z;
    int     stamp;
    int     stalls;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        carry_in;
  logic        sub_in;
  logic        ready_out;
  logic [31:0] a_raw;
  logic [31:0] b_raw;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int stall_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (!ready_out) stall_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: plain integer arithmetic and signed range test.
  function automatic void model(input int w, input longint a, input longint b,
                                input logic cin, input logic sub,
                                output longint sum, output logic c,
                                output logic ov, output logic z);
    longint m, sa, sb, r, sr;
    m  = longint'(1) << w;
    a  = a & (m - 1);
    b  = b & (m - 1);
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (sub) begin
      r  = a - b;
      c  = (a >= b);
      sr = sa - sb;
    end else begin
      r  = a + b + longint'(cin);
      c  = (r >= m);
      sr = sa + sb + longint'(cin);
    end
    sum = ((r % m) + m) % m;
    ov  = (sr >= m / 2) || (sr < -(m / 2));
    z   = (sum == 0);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int W = (g == 2) ? 32 : 8;
    localparam int N = (g == 0) ? 4 : (g == 1) ? 1 : 8;

    logic         ready_in;
    logic         valid_out;
    logic         carry_out;
    logic         overflow_out;
    logic         zero_out;
    logic [W-1:0] sum_out;

    exp_t   q[$];
    exp_t   e;
    longint s;
    logic   c, ov, z;

    pipelined_segmented_adder #(.DATA_WIDTH(W), .NUM_STAGES(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_in     (valid_in),
      .ready_in     (ready_in),
      .a_in         (a_raw[W-1:0]),
      .b_in         (b_raw[W-1:0]),
      .carry_in     (carry_in),
      .sub_in       (sub_in),
      .valid_out    (valid_out),
      .ready_out    (ready_out),
      .sum_out      (sum_out),
      .carry_out    (carry_out),
      .overflow_out (overflow_out),
      .zero_out     (zero_out)
    );

    always @(negedge clk) begin
      if (rst) begin
        q.delete();
      end else begin
        check($sformatf("ready_in[%0d]", g), ready_in, !(valid_out && !ready_out));
        if (valid_out) begin
          if (q.size() == 0) begin
            check($sformatf("stale_valid[%0d]", g), valid_out, 1'b0);
          end else begin
            e = q[0];
            check($sformatf("sum[%0d]", g), 64'(sum_out), e.sum);
            check($sformatf("carry[%0d]", g), carry_out, e.c);
            check($sformatf("overflow[%0d]", g), overflow_out, e.ov);
            check($sformatf("zero[%0d]", g), zero_out, e.z);
            if (ready_out) begin
              if (e.stalls == stall_cnt)
                check($sformatf("latency[%0d]", g), 64'(cyc - e.stamp), 64'(N));
              void'(q.pop_front());
            end
          end
        end
        if (valid_in && ready_in) begin
          model(W, longint'(a_raw[W-1:0]), longint'(b_raw[W-1:0]), carry_in, sub_in, s, c, ov, z);
          e.sum    = s;
          e.c      = c;
          e.ov     = ov;
          e.z      = z;
          e.stamp  = cyc;
          e.stalls = stall_cnt;
          q.push_back(e);
        end
      end
    end
  end

  // One beat through the 8-bit/4-stage instance with literal expectations.
  task automatic directed(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub, input logic [7:0] es,
                          input logic ec, input logic eov, input logic ez);
    @(posedge clk); #1;
    a_raw = {24'h0, a}; b_raw = {24'h0, b}; carry_in = cin; sub_in = sub; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check({name, "_early"}, g_cfg[0].valid_out, 1'b0);
    @(posedge clk); @(negedge clk);
    check({name, "_valid"}, g_cfg[0].valid_out, 1'b1);
    check({name, "_sum"}, 64'(g_cfg[0].sum_out), 64'(es));
    check({name, "_carry"}, g_cfg[0].carry_out, ec);
    check({name, "_ovf"}, g_cfg[0].overflow_out, eov);
    check({name, "_zero"}, g_cfg[0].zero_out, ez);
  endtask

  task automatic randomize_beat();
    valid_in = ($urandom_range(0, 3) != 0);
    a_raw    = $urandom;
    b_raw    = $urandom;
    carry_in = $urandom_range(0, 1);
    sub_in   = $urandom_range(0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    longint ms;
    logic   mc, mov, mz;
    int     sent, guard;

    rst = 1'b0; valid_in = 1'b0; a_raw = '0; b_raw = '0;
    carry_in = 1'b0; sub_in = 1'b0; ready_out = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_valid", g_cfg[0].valid_out, 1'b0);
    check("rst_sum", 64'(g_cfg[0].sum_out), 64'h0);
    check("rst_carry", g_cfg[0].carry_out, 1'b0);
    check("rst_ovf", g_cfg[0].overflow_out, 1'b0);
    check("rst_zero", g_cfg[0].zero_out, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 check("rst_ready_in", g_cfg[0].ready_in, 1'b1);

    model(8, 'h7F, 'h01, 1'b0, 1'b0, ms, mc, mov, mz);
    check("pin_add_sum", 64'(ms), 64'h80);
    check("pin_add_ovf", mov, 1'b1);
    model(8, 'h00, 'h01, 1'b0, 1'b1, ms, mc, mov, mz);
    check("pin_sub_sum", 64'(ms), 64'hFF);
    check("pin_sub_borrow", mc, 1'b0);
    model(32, 'h0, 'h1, 1'b0, 1'b1, ms, mc, mov, mz);
    check("pin_sub32_sum", 64'(ms), 64'hFFFF_FFFF);
    model(8, 'hFF, 'h00, 1'b1, 1'b0, ms, mc, mov, mz);
    check("pin_wrap_zero", mz, 1'b1);

    directed("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    directed("sub_05_05", 8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    directed("sub_00_01", 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    directed("add_ff_00_c", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    directed("sub_cin_ign", 8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
    directed("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);

    // 16 accepted beats with gaps and a 3-cycle downstream stall.
    sent = 0; guard = 0;
    while (sent < 16 && guard < 200) begin
      @(posedge clk); #1;
      ready_out = !(guard >= 6 && guard <= 8);
      randomize_beat();
      #1;
      if (valid_in && g_cfg[0].ready_in) sent++;
      guard++;
    end
    check("stream_beats_sent", 64'(sent), 64'd16);
    @(posedge clk); #1;
    valid_in = 1'b0; ready_out = 1'b1;
    repeat (12) @(posedge clk);

    // Five beats back-to-back, then reset with three still in flight.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      a_raw = 32'h11 + 32'(i); b_raw = 32'h22; carry_in = 1'b0; sub_in = 1'b0; valid_in = 1'b1;
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", g_cfg[0].valid_out, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", g_cfg[0].valid_out, 1'b0);
    check("midrst_sum", 64'(g_cfg[0].sum_out), 64'h0);
    check("midrst_carry", g_cfg[0].carry_out, 1'b0);
    check("midrst_ovf", g_cfg[0].overflow_out, 1'b0);
    check("midrst_zero", g_cfg[0].zero_out, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1 check("post_rst_ready", g_cfg[0].ready_in, 1'b1);
    directed("post_rst", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);

    // Random soak with random backpressure.
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      randomize_beat();
      ready_out = ($urandom_range(0, 9) < 7);
    end
    @(posedge clk); #1;
    valid_in = 1'b0; ready_out = 1'b1;
    repeat (14) @(posedge clk);
    @(negedge clk);
    check("drained[0]", 64'(g_cfg[0].q.size()), 64'd0);
    check("drained[1]", 64'(g_cfg[1].q.size()), 64'd0);
    check("drained[2]", 64'(g_cfg[2].q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
